seg_reg_stack: RTL and testbench

Parametrised successor to the team's 16-bit enabled segment register. Holds a current value Q, loadable like the plain register. Adds a LIFO save/restore stack of DEPTH entries so the datapath can save and restore segment state on calls and interrupts. Sits in the register stage wherever a DS-style segment register is instantiated today.

---
 rtl/seg_reg_stack.sv | 91 +++++++++
 tb/tb_seg_reg_stack.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/seg_reg_stack.sv
// Segment register with a LIFO save/restore stack for call/interrupt context.
// Q is loadable like the plain register; PUSH/POP save and restore it, and sticky flags record misuse.
module seg_reg_stack #(
  parameter int               WIDTH       = 16,
  parameter int               DEPTH       = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  localparam int              LW          = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic [WIDTH-1:0] d,
  input  logic             push,
  input  logic             pop,
  input  logic             clr_err,
  output logic [WIDTH-1:0] q,
  output logic [LW-1:0]    level,
  output logic             full,
  output logic             empty,
  output logic             ovf,
  output logic             unf
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] stack [DEPTH];
  logic [AW-1:0]    wr_idx;
  logic [AW-1:0]    top_idx;
  logic             do_swap;
  logic             do_push;

  assign full  = (level == LW'(DEPTH));
  assign empty = (level == '0);

  always_comb begin
    wr_idx  = AW'(level);
    top_idx = AW'(level - 1'b1);
    do_swap = push && pop && !empty;
    do_push = push && !pop && !full;
  end

  // NOTE: stack storage has no reset; entries beyond LEVEL are never read, so
  // resetting them would only cost area. Reset still blocks writes that cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      if (do_swap) begin
        stack[top_idx] <= q;
      end else if (do_push) begin
        stack[wr_idx] <= q;
      end
    end
  end

  // NOTE: all state uses non-blocking assignments so every branch sees the pre-edge Q and LEVEL.
  always_ff @(posedge clk) begin
    if (!rst) begin
      q     <= RESET_VALUE;
      level <= '0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else begin
      if (clr_err) begin
        ovf <= 1'b0;
        unf <= 1'b0;
      end
      if (pop) begin
        // POP outranks ENA; PUSH+POP is a swap that leaves LEVEL alone.
        if (empty) begin
          unf <= 1'b1;
        end else begin
          q <= stack[top_idx];
          if (!push) begin
            level <= level - 1'b1;
          end
        end
      end else begin
        if (ena) begin
          q <= d;
        end
        if (push) begin
          if (full) begin
            ovf <= 1'b1;
          end else begin
            level <= level + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_seg_reg_stack.sv
// Self-checking bench for seg_reg_stack: directed scenarios then random traffic,
// all compared against a queue-based reference model of the save/restore stack.
module tb_seg_reg_stack;

  localparam int              WIDTH = 16;
  localparam int              DEPTH = 4;
  localparam logic [WIDTH-1:0] RV   = 16'h0000;
  localparam int              LW    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst, ena, push, pop, clr_err;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
  logic [LW-1:0]    level;
  logic             full, empty, ovf, unf;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state
  logic [WIDTH-1:0] m_q;
  logic [WIDTH-1:0] m_stk[$];
  logic             m_ovf, m_unf;

  seg_reg_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_VALUE(RV)) dut (
    .clk(clk), .rst(rst), .ena(ena), .d(d), .push(push), .pop(pop),
    .clr_err(clr_err), .q(q), .level(level), .full(full), .empty(empty),
    .ovf(ovf), .unf(unf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_update(input logic r, input logic e, input logic [WIDTH-1:0] dv,
                              input logic pu, input logic po, input logic ce);
    logic             n_ovf, n_unf;
    logic [WIDTH-1:0] old_q, t;
    if (!r) begin
      m_q = RV;
      m_stk.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      n_ovf = 1'b0;
      n_unf = 1'b0;
      old_q = m_q;
      if (po) begin
        if (m_stk.size() == 0) n_unf = 1'b1;
        else if (pu) begin
          t = m_stk[m_stk.size() - 1];
          m_stk[m_stk.size() - 1] = old_q;
          m_q = t;
        end else m_q = m_stk.pop_back();
      end else begin
        if (e) m_q = dv;
        if (pu) begin
          if (m_stk.size() == DEPTH) n_ovf = 1'b1;
          else m_stk.push_back(old_q);
        end
      end
      if (ce) begin
        m_ovf = 1'b0;
        m_unf = 1'b0;
      end
      if (n_ovf) m_ovf = 1'b1;
      if (n_unf) m_unf = 1'b1;
    end
  endtask

  // Apply one cycle of inputs, advance the model, then compare every output #1 after the edge.
  task automatic step(input logic r, input logic e, input logic [WIDTH-1:0] dv,
                      input logic pu, input logic po, input logic ce);
    rst = r; ena = e; d = dv; push = pu; pop = po; clr_err = ce;
    @(posedge clk);
    model_update(r, e, dv, pu, po, ce);
    #1;
    check("q",     32'(q),     32'(m_q));
    check("level", 32'(level), 32'(m_stk.size()));
    check("full",  32'(full),  32'(m_stk.size() == DEPTH));
    check("empty", 32'(empty), 32'(m_stk.size() == 0));
    check("ovf",   32'(ovf),   32'(m_ovf));
    check("unf",   32'(unf),   32'(m_unf));
  endtask

  initial begin
    m_q = RV; m_ovf = 1'b0; m_unf = 1'b0;
    rst = 1'b0; ena = 1'b0; d = '0; push = 1'b0; pop = 1'b0; clr_err = 1'b0;

    // Reset and load
    step(0, 1, 16'h1234, 1, 0, 0);
    step(0, 0, 16'h0000, 0, 0, 0);
    check("rst_q", 32'(q), 32'h0000);
    check("rst_level", 32'(level), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    step(1, 1, 16'hABCD, 0, 0, 0);
    check("load_q", 32'(q), 32'hABCD);

    // Push/pop order
    step(1, 1, 16'h1111, 0, 0, 0);
    step(1, 1, 16'h2222, 1, 0, 0);
    check("pp1_level", 32'(level), 32'd1); check("pp1_q", 32'(q), 32'h2222);
    step(1, 1, 16'h3333, 1, 0, 0);
    check("pp2_level", 32'(level), 32'd2); check("pp2_q", 32'(q), 32'h3333);
    step(1, 0, 16'h0000, 0, 1, 0);
    check("pp3_level", 32'(level), 32'd1); check("pp3_q", 32'(q), 32'h2222);
    step(1, 0, 16'h0000, 0, 1, 0);
    check("pp4_level", 32'(level), 32'd0); check("pp4_q", 32'(q), 32'h1111);
    check("pp4_empty", 32'(empty), 32'd1);

    // Overflow
    step(1, 1, 16'h0005, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(1, 0, 16'h0000, 1, 0, 0);
    check("ovf_level", 32'(level), 32'd4);
    check("ovf_full", 32'(full), 32'd1);
    check("ovf_flag", 32'(ovf), 32'd1);
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 16'h0000, 0, 1, 0);
      check("ovf_pop_q", 32'(q), 32'h0005);
    end
    check("ovf_sticky", 32'(ovf), 32'd1);
    step(1, 0, 16'h0000, 0, 0, 1);

    // Underflow and priority
    step(1, 1, 16'hBEEF, 0, 1, 0);
    check("unf_q", 32'(q), 32'h0005);
    check("unf_flag", 32'(unf), 32'd1);
    check("unf_level", 32'(level), 32'd0);
    step(1, 0, 16'h0000, 0, 0, 1);
    check("unf_clr", 32'(unf), 32'd0);
    step(1, 0, 16'h0000, 0, 1, 1);
    check("unf_clr_vs_new", 32'(unf), 32'd1);
    step(1, 0, 16'h0000, 1, 1, 1);
    step(1, 0, 16'h0000, 0, 0, 1);

    // Swap
    step(1, 1, 16'h5555, 0, 0, 0);
    step(1, 1, 16'hAAAA, 1, 0, 0);
    step(1, 1, 16'h9999, 1, 1, 0);
    check("swap_q", 32'(q), 32'h5555);
    check("swap_level", 32'(level), 32'd1);
    step(1, 0, 16'h0000, 0, 1, 0);
    check("swap_pop_q", 32'(q), 32'hAAAA);

    // Swap when full must not flag overflow
    for (int i = 0; i < 4; i++) step(1, 1, 16'(16'h0100 + i), 1, 0, 0);
    step(1, 0, 16'h0000, 1, 1, 0);
    check("swap_full_ovf", 32'(ovf), 32'd0);
    check("swap_full_level", 32'(level), 32'd4);

    // Reset mid-operation
    step(1, 0, 16'h0000, 0, 0, 0);
    step(0, 1, 16'h7777, 1, 0, 0);
    check("midrst_level", 32'(level), 32'd0);
    check("midrst_q", 32'(q), 32'h0000);
    step(1, 0, 16'h0000, 0, 1, 0);
    check("midrst_unf", 32'(unf), 32'd1);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      step(($urandom_range(0, 99) != 0),
           1'($urandom_range(0, 1)),
           16'($urandom),
           ($urandom_range(0, 99) < 40),
           ($urandom_range(0, 99) < 35),
           ($urandom_range(0, 99) < 10));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
